byte_word_packer: RTL and testbench
===================================

BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 The block SHALL have one parameter: SWAP_NIBBLES, default 1; when 1, the assembled word is passed through common_functions::order_word (swap the two nibbles of every byte) before output; when 0, it is output unchanged.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_byte  input  8  byte data.
REQ-005 in_valid  input  1  in_byte is valid.
REQ-006 in_last  input  1  byte is the final byte of a frame; qualified by in_valid.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 out_word  output  32  packed word.
REQ-009 out_valid  output  1  out_word, out_last and out_bytes are valid.
REQ-010 out_last  output  1  word closes a frame.
REQ-011 out_bytes  output  3  count of meaningful bytes in out_word, 1..4.
REQ-012 out_ready  input  1  consumer accepts the word this cycle.

Function
REQ-013 A byte SHALL be accepted when in_valid && in_ready; a word SHALL be accepted when out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-015 Packing order SHALL be big-endian: the 1st byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-016 FSM states:
- EMPTY: byte count 0.
- FILL: byte count 1..3.
- Accepting a byte in EMPTY without in_last -> FILL.
- A word completes when the 4th byte is accepted, or when any byte with in_last is accepted; completion returns the FSM to EMPTY.
REQ-017 On completion, the word SHALL appear registered on the next cycle with:
- out_valid=1;
- out_last=in_last of the completing byte;
- out_bytes=number of bytes in the word.
REQ-018 Unfilled low-order bytes of a partial word SHALL be 0x00; nibble swap (if enabled) is applied after padding.
REQ-019 out_valid SHALL remain 1, and out_word/out_last/out_bytes SHALL remain stable, until the word is accepted.
REQ-020 If a word is accepted and a new word completes in the same cycle, the new word SHALL be loaded and out_valid SHALL stay 1 (no bubble).
REQ-021 With in_valid=1 and out_ready=1 continuously, throughput SHALL be 1 byte/cycle; output latency SHALL be 1 cycle after the completing byte.
REQ-022 A byte with in_last arriving as the 1st byte SHALL produce a 1-byte word (out_bytes=1).
REQ-023 While in_ready=0, bytes SHALL not be accepted and the partial-word state SHALL not change.

Reset
REQ-024 While rst=1:
- FSM SHALL go to EMPTY and byte count to 0;
- out_valid=0, out_last=0, out_bytes=0, out_word=0x00000000;
- any partial word SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-026 The FSM state typedef (EMPTY, FILL) and the constant WORD_BYTES=4 SHALL live in the shared package common_functions, alongside order_word/order_byte.
REQ-027 The block SHALL be a single module with no sub-modules; nibble swapping SHALL use the package function, not a local copy.

Verification
REQ-028 SWAP_NIBBLES=1, out_ready=1; bytes 0x12,0x34,0x56,0x78 on consecutive cycles, in_last on 0x78 -> out_word=0x21436587, out_bytes=4, out_last=1, out_valid for exactly 1 cycle, one cycle after 0x78.
REQ-029 SWAP_NIBBLES=0; same stimulus -> out_word=0x12345678.
REQ-030 SWAP_NIBBLES=1; bytes 0xAB,0xCD with in_last on 0xCD -> out_word=0xBADC0000, out_bytes=2, out_last=1.
REQ-031 SWAP_NIBBLES=0; 8 back-to-back bytes 0x01..0x08, out_ready=1 -> 0x01020304 then 0x05060708 on consecutive-word boundaries; in_ready never drops.
REQ-032 Backpressure: out_ready=0 after the first word completes -> in_ready=0, out_word stable for 10 cycles; raise out_ready -> word accepted and the next bytes resume with no loss or duplication.
REQ-033 Reset mid-fill: accept 0x11,0x22, then pulse rst for 1 cycle, then send 0x33,0x44,0x55,0x66 -> first output word is 0x33445566 (SWAP_NIBBLES=0); no word contains 0x11 or 0x22.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// common_functions
//   Shared definitions for the byte-to-word packer and its neighbours:
//   - pack_state_t : packer FSM states (EMPTY = no bytes held, FILL = 1..3 held)
//   - WORD_BYTES   : number of bytes in an output word
//   - order_byte   : swap the two nibbles of one byte
//   - order_word   : apply order_byte to every byte of a 32-bit word
// -----------------------------------------------------------------------------
package common_functions;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } pack_state_t;

    // Swap the high and low nibble of a byte.
    function automatic logic [7:0] order_byte(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    // Nibble-swap each byte in place; byte positions are unchanged.
    function automatic logic [31:0] order_word(input logic [31:0] w);
        return {order_byte(w[31:24]), order_byte(w[23:16]),
                order_byte(w[15:8]),  order_byte(w[7:0])};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//   Packs a byte stream into big-endian 32-bit words. A word is emitted when
//   its 4th byte is accepted or when a byte flagged in_last is accepted; a
//   short final word is zero-padded in its low-order bytes. Optionally every
//   byte of the emitted word is nibble-swapped (after padding).
//
// Parameters
//   SWAP_NIBBLES : 1 = pass word through order_word, 0 = output unchanged
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   in_byte    in   8  input byte
//   in_valid   in   1  in_byte valid
//   in_last    in   1  byte closes a frame (qualified by in_valid)
//   in_ready   out  1  byte accepted this cycle if in_valid (combinational)
//   out_word   out 32  packed word (registered)
//   out_valid  out  1  out_word/out_last/out_bytes valid
//   out_last   out  1  word closes a frame
//   out_bytes  out  3  meaningful bytes in out_word, 1..4
//   out_ready  in   1  consumer accepts the word this cycle
// -----------------------------------------------------------------------------
module byte_word_packer
    import common_functions::*;
#(
    parameter int unsigned SWAP_NIBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    output logic        out_last,
    output logic [2:0]  out_bytes,
    input  logic        out_ready
);

    // FSM and partial-word storage
    pack_state_t r_state;
    pack_state_t w_state_nxt;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;
    // Bytes already received, left-aligned: [23:16] first, [15:8] second, [7:0] third
    logic [23:0] r_acc;
    logic [23:0] w_acc_nxt;

    // Output holding register
    logic [31:0] r_word;
    logic        r_valid;
    logic        r_last;
    logic [2:0]  r_bytes;

    // Datapath helpers
    logic        w_in_ready;
    logic        w_accept;
    logic        w_complete;
    logic [31:0] w_word_asm;
    logic [31:0] w_word_out;
    logic [2:0]  w_bytes;

    // Handshake: a new byte can enter whenever the output slot is free or draining
    always_comb begin
        w_in_ready = !r_valid || out_ready;
        w_accept   = in_valid && w_in_ready;
        w_complete = w_accept && (in_last || (r_count == 2'd3));
        w_bytes    = {1'b0, r_count} + 3'd1;
    end

    // Word assembly: merge the incoming byte into its big-endian slot, zero below it
    always_comb begin
        w_word_asm = 32'h0000_0000;
        case (r_count)
            2'd0:    w_word_asm = {in_byte, 24'h00_0000};
            2'd1:    w_word_asm = {r_acc[23:16], in_byte, 16'h0000};
            2'd2:    w_word_asm = {r_acc[23:8], in_byte, 8'h00};
            2'd3:    w_word_asm = {r_acc, in_byte};
            default: w_word_asm = 32'h0000_0000;
        endcase
    end

    // Optional nibble swap, applied after zero padding
    always_comb begin
        if (SWAP_NIBBLES != 0) begin
            w_word_out = order_word(w_word_asm);
        end else begin
            w_word_out = w_word_asm;
        end
    end

    // FSM next-state: completion empties the packer, a plain accept appends a byte
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_acc_nxt   = r_acc;
        if (w_complete) begin
            w_state_nxt = EMPTY;
            w_count_nxt = 2'd0;
            w_acc_nxt   = 24'h00_0000;
        end else if (w_accept) begin
            w_state_nxt = FILL;
            w_count_nxt = r_count + 2'd1;
            // Upper 24 bits of the assembled word already hold the bytes in place
            w_acc_nxt   = w_word_asm[31:8];
        end else begin
            w_state_nxt = r_state;
            w_count_nxt = r_count;
            w_acc_nxt   = r_acc;
        end
    end

    // FSM state register with partial-word storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_count <= 2'd0;
            r_acc   <= 24'h00_0000;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Output register: load on completion (even while the previous word drains),
    // otherwise drop valid once the consumer takes the word, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_bytes <= 3'd0;
        end else if (w_complete) begin
            r_word  <= w_word_out;
            r_valid <= 1'b1;
            r_last  <= in_last;
            r_bytes <= w_bytes;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_word  = r_word;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_bytes = r_bytes;

endmodule

// File: tb/tb_byte_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_word_packer
//   Two packers share one input stream: u_swp (SWAP_NIBBLES=1) and
//   u_raw (SWAP_NIBBLES=0). Directed scenarios with hand-computed words.
//   Inputs change 1 ns after a rising edge; outputs are read at that point.
// -----------------------------------------------------------------------------
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        ir_s, ov_s, ol_s;
    logic [31:0] ow_s;
    logic [2:0]  ob_s;
    logic        ir_r, ov_r, ol_r;
    logic [31:0] ow_r;
    logic [2:0]  ob_r;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_word_packer #(.SWAP_NIBBLES(1)) u_swp (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir_s), .out_word(ow_s), .out_valid(ov_s),
        .out_last(ol_s), .out_bytes(ob_s), .out_ready(out_ready)
    );

    byte_word_packer #(.SWAP_NIBBLES(0)) u_raw (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir_r), .out_word(ow_r), .out_valid(ov_r),
        .out_last(ol_r), .out_bytes(ob_r), .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic l);
        in_byte  = b;
        in_valid = v;
        in_last  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(8'hFF, 1'b1, 1'b1); out_ready = 1'b1;
        step(); step();
        checks++;
        if ({ov_s, ol_s, ob_s, ow_s} !== 37'd0) begin
            errors++; $display("FAIL reset_swp: got v=%b l=%b b=%0d w=%h, want all 0", ov_s, ol_s, ob_s, ow_s);
        end
        checks++;
        if ({ov_r, ol_r, ob_r, ow_r} !== 37'd0) begin
            errors++; $display("FAIL reset_raw: got v=%b l=%b b=%0d w=%h, want all 0", ov_r, ol_r, ob_r, ow_r);
        end
        rst = 1'b0; drive(8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if ({ir_s, ir_r, ov_s, ov_r} !== 4'b1100) begin
            errors++; $display("FAIL reset_release: got ready=%b%b valid=%b%b, want ready=11 valid=00", ir_s, ir_r, ov_s, ov_r);
        end
    endtask

    task automatic test_full_word();
        logic [7:0] bytes_v [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(bytes_v[i], 1'b1, (i == 3));
            checks++;
            if (ir_s !== 1'b1) begin
                errors++; $display("FAIL full_ready[%0d]: got %b, want 1", i, ir_s);
            end
            step();
            if (i < 3) begin
                checks++;
                if (ov_s !== 1'b0) begin
                    errors++; $display("FAIL full_early_valid[%0d]: got %b, want 0", i, ov_s);
                end
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_s, ol_s, ob_s, ow_s} !== {1'b1, 1'b1, 3'd4, 32'h2143_6587}) begin
            errors++; $display("FAIL full_swp: got v=%b l=%b b=%0d w=%h, want 1 1 4 21436587", ov_s, ol_s, ob_s, ow_s);
        end
        checks++;
        if ({ov_r, ol_r, ob_r, ow_r} !== {1'b1, 1'b1, 3'd4, 32'h1234_5678}) begin
            errors++; $display("FAIL full_raw: got v=%b l=%b b=%0d w=%h, want 1 1 4 12345678", ov_r, ol_r, ob_r, ow_r);
        end
        step();
        checks++;
        if ({ov_s, ov_r} !== 2'b00) begin
            errors++; $display("FAIL full_one_cycle: got valid=%b%b, want 00", ov_s, ov_r);
        end
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        drive(8'hAB, 1'b1, 1'b0); step();
        drive(8'hCD, 1'b1, 1'b1); step();
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_s, ol_s, ob_s, ow_s} !== {1'b1, 1'b1, 3'd2, 32'hBADC_0000}) begin
            errors++; $display("FAIL partial_swp: got v=%b l=%b b=%0d w=%h, want 1 1 2 badc0000", ov_s, ol_s, ob_s, ow_s);
        end
        checks++;
        if ({ov_r, ob_r, ow_r} !== {1'b1, 3'd2, 32'hABCD_0000}) begin
            errors++; $display("FAIL partial_raw: got v=%b b=%0d w=%h, want 1 2 abcd0000", ov_r, ob_r, ow_r);
        end
        step();
    endtask

    // Single-byte frames back to back: also exercises reload without a bubble
    task automatic test_single_byte();
        out_ready = 1'b1;
        drive(8'h5A, 1'b1, 1'b1); step();
        drive(8'h6B, 1'b1, 1'b1);
        checks++;
        if ({ov_s, ol_s, ob_s, ow_s} !== {1'b1, 1'b1, 3'd1, 32'hA500_0000}) begin
            errors++; $display("FAIL single_swp: got v=%b l=%b b=%0d w=%h, want 1 1 1 a5000000", ov_s, ol_s, ob_s, ow_s);
        end
        step();
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_r, ol_r, ob_r, ow_r} !== {1'b1, 1'b1, 3'd1, 32'h6B00_0000}) begin
            errors++; $display("FAIL single_nobubble_raw: got v=%b l=%b b=%0d w=%h, want 1 1 1 6b000000", ov_r, ol_r, ob_r, ow_r);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(8'(i), 1'b1, 1'b0);
            if (ir_r !== 1'b1) drops++;
            step();
            if (i == 4) begin
                checks++;
                if ({ov_r, ol_r, ob_r, ow_r} !== {1'b1, 1'b0, 3'd4, 32'h0102_0304}) begin
                    errors++; $display("FAIL b2b_word0: got v=%b l=%b b=%0d w=%h, want 1 0 4 01020304", ov_r, ol_r, ob_r, ow_r);
                end
                checks++;
                if (ow_s !== 32'h1020_3040) begin
                    errors++; $display("FAIL b2b_word0_swp: got %h, want 10203040", ow_s);
                end
            end
            if (i == 5) begin
                checks++;
                if (ov_r !== 1'b0) begin
                    errors++; $display("FAIL b2b_gap: got valid=%b, want 0", ov_r);
                end
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_r, ob_r, ow_r} !== {1'b1, 3'd4, 32'h0506_0708}) begin
            errors++; $display("FAIL b2b_word1: got v=%b b=%0d w=%h, want 1 4 05060708", ov_r, ob_r, ow_r);
        end
        checks++;
        if (drops !== 0) begin
            errors++; $display("FAIL b2b_ready_drop: got %0d drops, want 0", drops);
        end
        step();
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'hA1 + 8'(i), 1'b1, 1'b0); step();
        end
        drive(8'hB1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (ir_r !== 1'b0 || ov_r !== 1'b1 || ow_r !== 32'hA1A2_A3A4) unstable++;
            step();
        end
        checks++;
        if (unstable !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d bad cycles, want 0 (ready=%b v=%b w=%h)", unstable, ir_r, ov_r, ow_r);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir_r !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b, want 1", ir_r);
        end
        step();
        checks++;
        if (ov_r !== 1'b0) begin
            errors++; $display("FAIL bp_accepted: got valid=%b, want 0", ov_r);
        end
        drive(8'hB2, 1'b1, 1'b0); step();
        drive(8'hB3, 1'b1, 1'b0); step();
        drive(8'hB4, 1'b1, 1'b1); step();
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_r, ol_r, ob_r, ow_r} !== {1'b1, 1'b1, 3'd4, 32'hB1B2_B3B4}) begin
            errors++; $display("FAIL bp_resume: got v=%b l=%b b=%0d w=%h, want 1 1 4 b1b2b3b4", ov_r, ol_r, ob_r, ow_r);
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        int seen_bad = 0;
        out_ready = 1'b1;
        drive(8'h11, 1'b1, 1'b0); step();
        drive(8'h22, 1'b1, 1'b0); step();
        drive(8'h00, 1'b0, 1'b0); rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'h33 + 8'(i) * 8'h11, 1'b1, 1'b0);
            step();
            if (i < 3 && ov_r !== 1'b0) seen_bad++;
        end
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ov_r, ow_r} !== {1'b1, 32'h3344_5566} || seen_bad !== 0) begin
            errors++; $display("FAIL rst_mid_fill: got v=%b w=%h early=%0d, want 1 33445566 0", ov_r, ow_r, seen_bad);
        end
        checks++;
        if (ow_s !== 32'h3344_5566) begin
            errors++; $display("FAIL rst_mid_fill_swp: got %h, want 33445566", ow_s);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        out_ready = 1'b1;
        test_reset();
        test_full_word();
        test_partial();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
